// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - parametrised up/down counter with load, wrap/saturate, tc pulse and sticky flags
// Optional count prescaler enabled by defining UPDN_CNT_PRESCALE_EN.
module updown_counter_mod #(
  parameter int              WIDTH    = 6,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cnt_ent,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             sat_mode,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf,
  output logic             unf,
  output logic             dir
);

  if (WIDTH < 2 || WIDTH > 32 || MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1) ||
      PRESCALE < 2 || PRESCALE > 256) begin : g_bad_params
    $error("updown_counter_mod: parameter out of range");
  end

  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_VAL);

  logic             up_req;
  logic             dn_req;
  logic             step_ok;
  logic             step;
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   ld_x;
  logic [WIDTH-1:0] cnt_n;
  logic             tc_n;
  logic             dir_n;
  logic             ovf_ev;
  logic             unf_ev;

  assign up_req = (cnt_ent == 2'b10);
  assign dn_req = (cnt_ent == 2'b01);

`ifdef UPDN_CNT_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] pre_q;

  assign step_ok = (pre_q == PW'(PRESCALE - 1));

  // Hold cycles freeze the prescaler; a direction change keeps its phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else if (ld) begin
      pre_q <= '0;
    end else if (up_req || dn_req) begin
      pre_q <= step_ok ? '0 : pre_q + PW'(1);
    end
  end
`else
  assign step_ok = 1'b1;
`endif

  assign step  = !ld && (up_req || dn_req) && step_ok;
  assign cnt_x = {1'b0, cnt};
  assign ld_x  = {1'b0, ld_val};

  always_comb begin
    cnt_n  = cnt;
    tc_n   = 1'b0;
    dir_n  = dir;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    if (ld) begin
      cnt_n = (ld_x > MAX_W) ? MAX_W[WIDTH-1:0] : ld_val;
    end else if (step && up_req) begin
      dir_n = 1'b1;
      if (cnt_x < MAX_W) begin
        cnt_n = WIDTH'(cnt_x + 1'b1);
      end else begin
        ovf_ev = 1'b1;
        if (!sat_mode) begin
          cnt_n = '0;
          tc_n  = 1'b1;
        end
      end
    end else if (step && dn_req) begin
      dir_n = 1'b0;
      if (cnt_x != '0) begin
        cnt_n = WIDTH'(cnt_x - 1'b1);
      end else begin
        unf_ev = 1'b1;
        if (!sat_mode) begin
          cnt_n = MAX_W[WIDTH-1:0];
          tc_n  = 1'b1;
        end
      end
    end
  end

  // A new overflow/underflow event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
      dir <= 1'b1;
    end else begin
      cnt <= cnt_n;
      tc  <= tc_n;
      dir <= dir_n;
      ovf <= ovf_ev | (ovf & ~clr_flags);
      unf <= unf_ev | (unf & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - self-checking bench for updown_counter_mod (full range and MAX_VAL=9 instances)
module tb_updown_counter_mod;

`ifdef UPDN_CNT_PRESCALE_EN
  localparam int STEP_CYC = 4;
`else
  localparam int STEP_CYC = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cnt_ent = 2'b00;
  logic       ld = 1'b0;
  logic [5:0] ld_val = '0;
  logic       sat_mode = 1'b0;
  logic       clr_flags = 1'b0;
  logic [5:0] cnt_a, cnt_b;
  logic       tc_a, ovf_a, unf_a, dir_a;
  logic       tc_b, ovf_b, unf_b, dir_b;

  int checks = 0;
  int errors = 0;

  int m_cnt[2];
  bit m_tc[2], m_ovf[2], m_unf[2], m_dir[2];
  int m_pre[2];
  int mx[2] = '{63, 9};

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(6), .PRESCALE(4)) dut_a (
    .clk(clk), .rst(rst), .cnt_ent(cnt_ent), .ld(ld), .ld_val(ld_val), .sat_mode(sat_mode),
    .clr_flags(clr_flags), .cnt(cnt_a), .tc(tc_a), .ovf(ovf_a), .unf(unf_a), .dir(dir_a));

  updown_counter_mod #(.WIDTH(6), .MAX_VAL(9), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .cnt_ent(cnt_ent), .ld(ld), .ld_val(ld_val), .sat_mode(sat_mode),
    .clr_flags(clr_flags), .cnt(cnt_b), .tc(tc_b), .ovf(ovf_b), .unf(unf_b), .dir(dir_b));

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_dir[k] = 1; m_pre[k] = 0;
    end
  endfunction

  // Reference: integer counting in 0..max with the spec's wrap/saturate rules.
  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      int nc = m_cnt[k];
      bit ntc = 0, ov = 0, un = 0, fire;
      if (ld) begin
        nc = (int'(ld_val) > mx[k]) ? mx[k] : int'(ld_val);
        m_pre[k] = 0;
      end else if (cnt_ent == 2'b10 || cnt_ent == 2'b01) begin
        fire = 1;
        if (STEP_CYC > 1) begin
          m_pre[k] = m_pre[k] + 1;
          fire = (m_pre[k] == STEP_CYC);
          if (fire) m_pre[k] = 0;
        end
        if (fire && cnt_ent == 2'b10) begin
          m_dir[k] = 1;
          if (nc == mx[k]) begin ov = 1; if (!sat_mode) begin nc = 0; ntc = 1; end end
          else nc = nc + 1;
        end else if (fire) begin
          m_dir[k] = 0;
          if (nc == 0) begin un = 1; if (!sat_mode) begin nc = mx[k]; ntc = 1; end end
          else nc = nc - 1;
        end
      end
      m_ovf[k] = ov || (m_ovf[k] && !clr_flags);
      m_unf[k] = un || (m_unf[k] && !clr_flags);
      m_cnt[k] = nc;
      m_tc[k]  = ntc;
    end
  endfunction

  function automatic logic [9:0] exp_vec(input int k);
    return {6'(m_cnt[k]), m_tc[k], m_ovf[k], m_unf[k], m_dir[k]};
  endfunction

  function automatic logic [9:0] obs_vec(input int k);
    return (k == 0) ? {cnt_a, tc_a, ovf_a, unf_a, dir_a} : {cnt_b, tc_b, ovf_b, unf_b, dir_b};
  endfunction

  task automatic drive(input logic [1:0] e, input logic l, input logic [5:0] v,
                       input logic s, input logic c);
    cnt_ent = e; ld = l; ld_val = v; sat_mode = s; clr_flags = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step_n(input logic [1:0] e, input logic s, input logic c);
    for (int i = 0; i < STEP_CYC; i++) drive(e, 1'b0, 6'd0, s, c);
  endtask

  task automatic test_reset();
    rst = 1'b1; #2; rst = 1'b0; #2;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== 10'b000000_0001) begin
        errors++; $display("FAIL reset_state dut%0d got %h want %h", k, obs_vec(k), 10'b000000_0001);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_count_up();
    for (int i = 1; i <= 5; i++) begin
      step_n(2'b10, 1'b0, 1'b0);
      checks++;
      if (cnt_a !== 6'(i) || dir_a !== 1'b1 || tc_a !== 1'b0) begin
        errors++; $display("FAIL count_up cnt=%0d dir=%b tc=%b want cnt=%0d dir=1 tc=0", cnt_a, dir_a, tc_a, i);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL count_up_model dut%0d got %h want %h", k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_wrap_up();
    drive(2'b00, 1'b1, 6'd8, 1'b0, 1'b0);
    step_n(2'b10, 1'b0, 1'b0);
    checks++;
    if (cnt_b !== 6'd9) begin errors++; $display("FAIL wrap_up_9 got %0d want 9", cnt_b); end
    step_n(2'b10, 1'b0, 1'b0);
    checks++;
    if ({cnt_b, tc_b, ovf_b} !== {6'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL wrap_up_0 cnt=%0d tc=%b ovf=%b want 0 1 1", cnt_b, tc_b, ovf_b);
    end
    drive(2'b00, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if ({tc_b, ovf_b} !== 2'b01) begin
      errors++; $display("FAIL wrap_up_hold tc=%b ovf=%b want tc=0 ovf=1", tc_b, ovf_b);
    end
    checks++;
    if (obs_vec(0) !== exp_vec(0)) begin
      errors++; $display("FAIL wrap_up_model dut0 got %h want %h", obs_vec(0), exp_vec(0));
    end
  endtask

  task automatic test_wrap_down_sat();
    drive(2'b00, 1'b1, 6'd0, 1'b0, 1'b0);
    step_n(2'b01, 1'b0, 1'b0);
    checks++;
    if ({cnt_b, unf_b, tc_b, dir_b} !== {6'd9, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL wrap_down cnt=%0d unf=%b tc=%b dir=%b want 9 1 1 0", cnt_b, unf_b, tc_b, dir_b);
    end
    drive(2'b00, 1'b1, 6'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_n(2'b01, 1'b1, 1'b0);
      checks++;
      if ({cnt_b, tc_b, unf_b} !== {6'd0, 1'b0, 1'b1}) begin
        errors++; $display("FAIL sat_down cnt=%0d tc=%b unf=%b want 0 0 1", cnt_b, tc_b, unf_b);
      end
    end
    drive(2'b00, 1'b0, 6'd0, 1'b0, 1'b1);
    checks++;
    if (unf_b !== 1'b0 || unf_a !== 1'b0) begin
      errors++; $display("FAIL clr_flags unf_b=%b unf_a=%b want 0 0", unf_b, unf_a);
    end
  endtask

  task automatic test_priority_clamp();
    drive(2'b10, 1'b1, 6'd63, 1'b0, 1'b0);
    checks++;
    if ({cnt_b, cnt_a, tc_b} !== {6'd9, 6'd63, 1'b0}) begin
      errors++; $display("FAIL ld_clamp cnt_b=%0d cnt_a=%0d tc_b=%b want 9 63 0", cnt_b, cnt_a, tc_b);
    end
  endtask

  task automatic test_flag_set_wins();
    drive(2'b00, 1'b1, 6'd9, 1'b0, 1'b1);
    checks++;
    if (ovf_b !== 1'b0) begin errors++; $display("FAIL pre_clear ovf=%b want 0", ovf_b); end
    step_n(2'b10, 1'b0, 1'b1);
    checks++;
    if ({ovf_b, cnt_b, tc_b} !== {1'b1, 6'd0, 1'b1}) begin
      errors++; $display("FAIL set_wins ovf=%b cnt=%0d tc=%b want 1 0 1", ovf_b, cnt_b, tc_b);
    end
  endtask

  task automatic test_async_reset();
    drive(2'b00, 1'b1, 6'd5, 1'b0, 1'b0);
    checks++;
    if (cnt_b !== 6'd5 || ovf_b !== 1'b1) begin
      errors++; $display("FAIL pre_async cnt=%0d ovf=%b want 5 1", cnt_b, ovf_b);
    end
    #2; rst = 1'b0; #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        errors++; $display("FAIL async_reset dut%0d got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

`ifdef UPDN_CNT_PRESCALE_EN
  task automatic test_prescaler();
    drive(2'b00, 1'b1, 6'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      drive(2'b10, 1'b0, 6'd0, 1'b0, 1'b0);
      checks++;
      if (cnt_b !== 6'(i / 4)) begin
        errors++; $display("FAIL prescale_up edge %0d cnt=%0d want %0d", i, cnt_b, i / 4);
      end
    end
    drive(2'b00, 1'b1, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(2'b10, 1'b0, 6'd0, 1'b0, 1'b0);
    drive(2'b00, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (cnt_b !== 6'd0) begin errors++; $display("FAIL prescale_hold cnt=%0d want 0", cnt_b); end
    drive(2'b10, 1'b0, 6'd0, 1'b0, 1'b0);
    checks++;
    if (cnt_b !== 6'd1) begin errors++; $display("FAIL prescale_delayed cnt=%0d want 1", cnt_b); end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), 6'($urandom_range(0, 63)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL random cyc %0d dut%0d got %h want %h", n, k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down_sat();
    test_priority_clamp();
    test_flag_set_wins();
    test_async_reset();
`ifdef UPDN_CNT_PRESCALE_EN
    test_prescaler();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised up/down counter; successor to the fixed 6-bit up counter.
- Counter width and modulus are configurable.
- Adds synchronous load, a wrap/saturate mode, a terminal-count pulse and sticky overflow/underflow flags.
- Used as the general event/position counter in the lab datapath blocks; drives status logic and downstream FSMs.

Parameters:
- WIDTH, 6, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, top count value; count range is 0..MAX_VAL. Must be ≤ 2**WIDTH-1 and ≥1.
- PRESCALE, 4, enabled cycles per count step; used only with UPDN_CNT_PRESCALE_EN (2..256).

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-low reset.
- cnt_ent, in, 2: count enable/direction; 10 = up, 01 = down, 00 and 11 = hold.
- ld, in, 1: synchronous load strobe.
- ld_val, in, WIDTH: load value.
- sat_mode, in, 1: 0 = wrap (modulo MAX_VAL+1), 1 = saturate at 0/MAX_VAL.
- clr_flags, in, 1: synchronous clear of ovf/unf.
- cnt, out, WIDTH: registered count.
- tc, out, 1: one-cycle terminal-count pulse on a wrap.
- ovf, out, 1: sticky overflow flag.
- unf, out, 1: sticky underflow flag.
- dir, out, 1: direction of last step (1 = up); holds while idle.

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, tc=0, ovf=0, unf=0, dir=1, prescaler=0. Takes effect immediately.
- Reset deassertion is synchronised by the caller; the first active edge after release may count.
- All outputs are registered. A step takes effect on the clk edge where the input is sampled, so cnt shows the new value one cycle after the request.
- Priority per edge: ld > count step > hold.
- ld=1:
  - cnt <= min(ld_val, MAX_VAL).
  - tc <= 0.
  - Prescaler clears.
  - dir unchanged; flags unchanged.
- Up step, cnt < MAX_VAL: cnt+1, dir <= 1.
- Up step, cnt == MAX_VAL:
  - Wrap mode: cnt <= 0, tc <= 1, ovf <= 1.
  - Saturate mode: cnt holds at MAX_VAL, ovf <= 1, tc <= 0.
- Down step, cnt > 0: cnt-1, dir <= 0.
- Down step, cnt == 0:
  - Wrap mode: cnt <= MAX_VAL, tc <= 1, unf <= 1.
  - Saturate mode: cnt holds at 0, unf <= 1, tc <= 0.
- tc is 1 only in the cycle immediately after a wrap edge; otherwise 0. Back-to-back wraps (MAX_VAL=1) give a continuous tc.
- Hold (00/11): cnt, dir and flags unchanged; tc <= 0.
- clr_flags: ovf <= 0 and unf <= 0, unless a new ovf/unf event occurs on the same edge; set wins.
- sat_mode may change on any cycle; it is sampled on the same edge as the step.
- Arithmetic is done at WIDTH+1 bits internally. No intermediate value exceeds MAX_VAL. Counting is not restricted to powers of two.

Optional Feature:
- Macro: UPDN_CNT_PRESCALE_EN.
- Defined:
  - An internal $clog2(PRESCALE)-bit prescaler advances on every cycle where cnt_ent is 10 or 01 (and ld=0).
  - A count step occurs only on the edge where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - Hold cycles freeze the prescaler.
  - A direction change does not clear the prescaler.
  - ld and reset clear it.
- Not defined: every enabled cycle is a step; PRESCALE is ignored; no prescaler logic.

Test Plan:
- Reset and count up (WIDTH=6, default MAX_VAL): rst=0, then release with cnt_ent=10 for 5 cycles → cnt 0,1,2,3,4,5; dir=1; tc=0.
- Modulo wrap up (MAX_VAL=9, sat_mode=0): ld 8, then up ×2 → cnt 9, then 0 with tc=1 for one cycle and ovf=1 sticky; a later hold keeps ovf=1 and tc=0.
- Wrap down and saturate (MAX_VAL=9):
  - cnt=0, down, sat_mode=0 → cnt=9, unf=1, tc=1.
  - ld 0, sat_mode=1, down ×3 → cnt stays 0, tc=0.
  - clr_flags → unf=0.
- Priority and clamp: ld=1 with ld_val=63 (MAX_VAL=9) and cnt_ent=10 on the same edge → cnt=9, no step.
- Flag set wins: clr_flags=1 on the same edge as an up wrap → ovf=1.
- Async reset mid-count: cnt=5, drive rst=0 between edges → cnt=0, ovf=0 and unf=0 immediately, without waiting for clk.
- Prescaler (UPDN_CNT_PRESCALE_EN, PRESCALE=4):
  - up for 8 cycles → cnt increments on the 4th and 8th enabled edges only, giving 2.
  - A hold cycle in between delays the 4th step by one cycle.
